// File: rtl/dma_peripheral_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_peripheral_requester_if
// Purpose  : DREQ/DACK handshake and system data bus for one DMA channel.
// Revision : 1.0
// ============================================================================
interface dma_peripheral_requester_if;
    logic       DACK;
    logic       IOR_N;
    logic       IOW_N;
    logic       EOP_N;
    logic [7:0] DB_in;
    logic [7:0] DB_out;
    logic       DB_oe;
    logic       DREQ;

    modport master (
        output DACK, IOR_N, IOW_N, EOP_N, DB_in,
        input  DB_out, DB_oe, DREQ
    );

    modport slave (
        input  DACK, IOR_N, IOW_N, EOP_N, DB_in,
        output DB_out, DB_oe, DREQ
    );
endinterface
`default_nettype wire

// File: rtl/dma_peripheral_requester.sv
`default_nettype none
// ============================================================================
// Module   : dma_peripheral_requester
// Purpose  : Peripheral DREQ/DACK endpoint with a local byte FIFO.
// Revision : 1.0
// ============================================================================
module dma_peripheral_requester #(
    parameter int DEPTH     = 8,
    parameter int THRESHOLD = 4
) (
    input  wire logic                   CLK,
    input  wire logic                   RESET,
    input  wire logic                   enable,
    input  wire logic                   dirToMem,
    input  wire logic                   singleMode,
    input  wire logic                   flush,
    input  wire logic                   push,
    input  wire logic [7:0]             pushData,
    input  wire logic                   pop,
    output logic      [7:0]             popData,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        done,
    output logic                        overflow,
    output logic                        underflow,
    dma_peripheral_requester_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_THRESH = CW'(THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_XFER = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_dir, r_flush, r_ior_q, r_iow_q;
    logic          r_dreq, r_done, r_ovf, r_unf;
    logic [7:0]    r_db_lat;

    logic          w_empty, w_full, w_dir, w_xfer;
    logic          w_ior_rise, w_iow_rise;
    logic          w_bus_pop, w_bus_push, w_loc_push, w_loc_pop;
    logic          w_wr, w_rd, w_commit, w_req, w_cont;
    logic [7:0]    w_wdata;
    logic [CW-1:0] w_count_nxt;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    // Direction is live while idle so the first request reflects the current setting.
    assign w_dir      = (r_state == S_IDLE) ? dirToMem : r_dir;
    assign w_xfer     = (r_state == S_XFER) && bus.DACK;
    assign w_ior_rise = !r_ior_q && bus.IOR_N;
    assign w_iow_rise = !r_iow_q && bus.IOW_N;

    assign w_bus_pop  = w_xfer && r_dir  && w_ior_rise && !w_empty;
    assign w_bus_push = w_xfer && !r_dir && w_iow_rise && !w_full;
    assign w_loc_push = push && !w_full  && !w_bus_push;
    assign w_loc_pop  = pop  && !w_empty && !w_bus_pop;
    assign w_wr       = w_bus_push || w_loc_push;
    assign w_rd       = w_bus_pop  || w_loc_pop;
    assign w_commit   = w_bus_pop  || w_bus_push;
    assign w_wdata    = w_bus_push ? r_db_lat : pushData;

    assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_wr} - {{(CW-1){1'b0}}, w_rd};

    assign w_req  = w_dir ? ((r_count >= C_THRESH) || (r_flush && !w_empty))
                          : ((C_DEPTH - r_count) >= C_THRESH);
    // Once granted, a block keeps going until the FIFO runs dry (or fills).
    assign w_cont = r_dir ? (w_count_nxt != '0) : (w_count_nxt != C_DEPTH);

    assign popData    = r_mem[r_rd_ptr];
    assign bus.DB_oe  = w_xfer && r_dir && !bus.IOR_N;
    assign bus.DB_out = bus.DB_oe ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.DREQ   = r_dreq;
    assign count      = r_count;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign underflow  = r_unf;

    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dir    <= 1'b0;
            r_flush  <= 1'b0;
            r_ior_q  <= 1'b1;
            r_iow_q  <= 1'b1;
            r_db_lat <= 8'h00;
            r_dreq   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_ior_q <= bus.IOR_N;
            r_iow_q <= bus.IOW_N;
            if (!bus.IOW_N) r_db_lat <= bus.DB_in;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;

            if (flush && w_dir) r_flush <= 1'b1;
            else if (w_empty)   r_flush <= 1'b0;

            if (r_state == S_IDLE) r_dir <= dirToMem;

            if (!enable) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (push && w_full) r_ovf <= 1'b1;
                if (pop && w_empty) r_unf <= 1'b1;
            end

            if (!enable) begin
                r_state <= S_IDLE;
                r_dreq  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_req) begin
                            r_state <= S_REQ;
                            r_dreq  <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (bus.DACK) r_state <= S_XFER;
                    end
                    S_XFER: begin
                        // A byte whose strobe edge coincides with EOP still commits above.
                        if (!bus.EOP_N && bus.DACK) begin
                            r_state <= S_DONE;
                            r_dreq  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (singleMode && w_commit) begin
                            r_state <= S_HOLD;
                            r_dreq  <= 1'b0;
                        end else if (!w_cont) begin
                            r_state <= S_IDLE;
                            r_dreq  <= 1'b0;
                        end else if (!bus.DACK) begin
                            r_state <= S_REQ;
                        end
                    end
                    S_HOLD: begin
                        if (!bus.DACK) r_state <= S_IDLE;
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_dreq  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dma_peripheral_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_peripheral_requester
// Purpose  : Directed, table-driven bench for dma_peripheral_requester.
// Revision : 1.0
// ============================================================================
module tb_dma_peripheral_requester;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       enable, dirToMem, singleMode, flush, push, pop;
    logic [7:0] pushData;
    logic [7:0] popData;
    logic [3:0] count;
    logic       done, overflow, underflow;

    dma_peripheral_requester_if bus();

    dma_peripheral_requester #(.DEPTH(8), .THRESHOLD(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .enable     (enable),
        .dirToMem   (dirToMem),
        .singleMode (singleMode),
        .flush      (flush),
        .push       (push),
        .pushData   (pushData),
        .pop        (pop),
        .popData    (popData),
        .count      (count),
        .done       (done),
        .overflow   (overflow),
        .underflow  (underflow),
        .bus        (bus.slave)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
        logic       chk_head;
        logic [7:0] head;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_dreq(input string name, input int budget);
        int n = 0;
        while (bus.DREQ !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(bus.DREQ), 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] d);
        push = 1'b1; pushData = d;
        step();
        push = 1'b0;
    endtask

    task automatic ior_pulse();
        bus.IOR_N = 1'b0; step();
        bus.IOR_N = 1'b1; step();
    endtask

    initial begin
        RESET = 1'b1; enable = 1'b0; dirToMem = 1'b1; singleMode = 1'b0;
        flush = 1'b0; push = 1'b0; pop = 1'b0; pushData = 8'h00;
        bus.DACK = 1'b0; bus.IOR_N = 1'b1; bus.IOW_N = 1'b1; bus.EOP_N = 1'b1;
        bus.DB_in = 8'h00;

        // Boundary table: nine pushes into an 8-deep FIFO, eight pops, one empty pop.
        for (int i = 0; i < 9; i++) begin
            tbl[i].push = 1'b1; tbl[i].pop = 1'b0; tbl[i].din = 8'(8'hB0 + i);
            tbl[i].cnt = (i < 8) ? 4'(i + 1) : 4'd8;
            tbl[i].ovf = (i == 8); tbl[i].unf = 1'b0;
            tbl[i].chk_head = 1'b0; tbl[i].head = 8'h00;
        end
        for (int j = 0; j < 8; j++) begin
            tbl[9+j].push = 1'b0; tbl[9+j].pop = 1'b1; tbl[9+j].din = 8'h00;
            tbl[9+j].cnt = 4'(7 - j); tbl[9+j].ovf = 1'b1; tbl[9+j].unf = 1'b0;
            tbl[9+j].chk_head = 1'b1; tbl[9+j].head = 8'(8'hB0 + j);
        end
        tbl[17].push = 1'b0; tbl[17].pop = 1'b1; tbl[17].din = 8'h00; tbl[17].cnt = 4'd0;
        tbl[17].ovf = 1'b1; tbl[17].unf = 1'b1; tbl[17].chk_head = 1'b0; tbl[17].head = 8'h00;

        // Reset state
        step(); step();
        RESET = 1'b0;
        step();
        chk("rst_dreq",  32'(bus.DREQ),   32'd0);
        chk("rst_oe",    32'(bus.DB_oe),  32'd0);
        chk("rst_dbout", 32'(bus.DB_out), 32'd0);
        chk("rst_count", 32'(count),      32'd0);
        chk("rst_flags", 32'({done, overflow, underflow}), 32'd0);

        // Device-to-memory demand transfer
        enable = 1'b1; dirToMem = 1'b1; singleMode = 1'b0;
        step();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        chk("d2m_count4", 32'(count), 32'd4);
        chk("d2m_dreq_not_yet", 32'(bus.DREQ), 32'd0);
        step();
        chk("d2m_dreq_up", 32'(bus.DREQ), 32'd1);
        bus.DACK = 1'b1; step();
        for (int k = 0; k < 4; k++) begin
            bus.IOR_N = 1'b0; #1;
            chk("d2m_oe", 32'(bus.DB_oe), 32'd1);
            chk("d2m_dbout", 32'(bus.DB_out), 32'(8'h11 * (k + 1)));
            step();
            bus.IOR_N = 1'b1; step();
            chk("d2m_count", 32'(count), 32'(3 - k));
        end
        chk("d2m_dreq_down", 32'(bus.DREQ), 32'd0);
        bus.DACK = 1'b0; step();
        chk("d2m_idle_dreq", 32'(bus.DREQ), 32'd0);

        // Memory-to-device single mode
        enable = 1'b0; step();
        dirToMem = 1'b0; singleMode = 1'b1; enable = 1'b1;
        step();
        chk("m2d_dreq_up", 32'(bus.DREQ), 32'd1);
        bus.DACK = 1'b1; step();
        bus.DB_in = 8'hA5; bus.IOW_N = 1'b0; step();
        chk("m2d_oe_off", 32'(bus.DB_oe), 32'd0);
        bus.IOW_N = 1'b1; step();
        bus.DB_in = 8'h00;
        chk("m2d_count1", 32'(count), 32'd1);
        chk("m2d_hold_dreq", 32'(bus.DREQ), 32'd0);
        bus.DACK = 1'b0; step();
        wait_dreq("m2d_dreq_again", 3);
        chk("m2d_popdata", 32'(popData), 32'hA5);
        pop = 1'b1; step(); pop = 1'b0;
        chk("m2d_count0", 32'(count), 32'd0);

        // EOP termination with six bytes queued
        enable = 1'b0; step();
        dirToMem = 1'b1; singleMode = 1'b0;
        for (int k = 0; k < 6; k++) push_byte(8'(8'h60 + k));
        enable = 1'b1; step();
        bus.DACK = 1'b1; step();
        ior_pulse();
        chk("eop_count5", 32'(count), 32'd5);
        bus.IOR_N = 1'b0; step();
        bus.IOR_N = 1'b1; bus.EOP_N = 1'b0; step();
        bus.EOP_N = 1'b1;
        chk("eop_count4", 32'(count), 32'd4);
        chk("eop_done",   32'(done), 32'd1);
        chk("eop_dreq",   32'(bus.DREQ), 32'd0);
        bus.DACK = 1'b0; step(); step(); step();
        chk("eop_dreq_stays", 32'(bus.DREQ), 32'd0);
        enable = 1'b0; step();
        chk("eop_done_clr", 32'(done), 32'd0);
        enable = 1'b1; step();
        chk("eop_rearm_dreq", 32'(bus.DREQ), 32'd1);

        // Preemption mid-block
        bus.DACK = 1'b1; step();
        ior_pulse();
        chk("pre_count3", 32'(count), 32'd3);
        bus.DACK = 1'b0; step();
        chk("pre_dreq_held", 32'(bus.DREQ), 32'd1);
        bus.IOR_N = 1'b0; #1;
        chk("pre_oe_off", 32'(bus.DB_oe), 32'd0);
        step();
        bus.IOR_N = 1'b1; step();
        chk("pre_no_pop", 32'(count), 32'd3);
        bus.DACK = 1'b1; step();
        for (int k = 0; k < 3; k++) begin
            bus.IOR_N = 1'b0; #1;
            chk("pre_dbout", 32'(bus.DB_out), 32'(8'h63 + k));
            step();
            bus.IOR_N = 1'b1; step();
        end
        chk("pre_count0", 32'(count), 32'd0);
        chk("pre_dreq_down", 32'(bus.DREQ), 32'd0);
        bus.DACK = 1'b0;

        // Local push with bus pop in the same cycle, then async reset mid-strobe
        enable = 1'b0; step();
        for (int k = 0; k < 4; k++) push_byte(8'(8'h70 + k));
        enable = 1'b1; step();
        bus.DACK = 1'b1; step();
        bus.IOR_N = 1'b0; step();
        bus.IOR_N = 1'b1; push = 1'b1; pushData = 8'h74; step();
        push = 1'b0;
        chk("sim_count", 32'(count), 32'd4);
        bus.IOR_N = 1'b0; #1;
        chk("sim_oe", 32'(bus.DB_oe), 32'd1);
        chk("sim_head", 32'(bus.DB_out), 32'h71);
        #1 RESET = 1'b1;
        #1;
        chk("arst_oe",    32'(bus.DB_oe),  32'd0);
        chk("arst_dreq",  32'(bus.DREQ),   32'd0);
        chk("arst_count", 32'(count),      32'd0);
        chk("arst_dbout", 32'(bus.DB_out), 32'd0);
        RESET = 1'b0; bus.IOR_N = 1'b1; bus.DACK = 1'b0; enable = 1'b0;
        step();

        // Overflow / underflow boundaries
        enable = 1'b1; dirToMem = 1'b1; step();
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].chk_head) chk("tbl_head", 32'(popData), 32'(tbl[i].head));
            push = tbl[i].push; pop = tbl[i].pop; pushData = tbl[i].din;
            step();
            push = 1'b0; pop = 1'b0;
            chk("tbl_count", 32'(count),     32'(tbl[i].cnt));
            chk("tbl_ovf",   32'(overflow),  32'(tbl[i].ovf));
            chk("tbl_unf",   32'(underflow), 32'(tbl[i].unf));
        end

        // Flush requests below threshold
        enable = 1'b0; step();
        push_byte(8'hC0); push_byte(8'hC1);
        enable = 1'b1; step(); step();
        chk("flush_no_req", 32'(bus.DREQ), 32'd0);
        flush = 1'b1; step(); flush = 1'b0;
        wait_dreq("flush_dreq", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
